alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter that shares one combinational `Alu` instance in the pipeline CPU. It sits between the `Alu` and its two users, for example the EX stage and an address/branch-compare unit. It accepts one operation per cycle with a valid/ready handshake, drives the `Alu` operands and opcode, and captures result and zero flag into a per-requester response register. Each response register holds its result until that requester takes it.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width.
- `ALUC_W`, 4, `Alu` opcode width (`i_aluc` encoding passed through unmodified).

Ports (N = 0, 1):
- `i_clk`  in  1  sole clock, rising edge.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_reqN_valid`  in  1  requester N has an operation.
- `o_reqN_ready`  out  1  operation of requester N accepted this cycle.
- `i_reqN_r`  in  WIDTH  operand r.
- `i_reqN_s`  in  WIDTH  operand s.
- `i_reqN_aluc`  in  ALUC_W  ALU opcode.
- `o_rspN_valid`  out  1  response register N holds a result.
- `i_rspN_ready`  in  1  requester N consumes the response.
- `o_rspN_alu`  out  WIDTH  captured `Alu` result.
- `o_rspN_zf`  out  1  captured `Alu` zero flag.
- `o_alu_r`, `o_alu_s`  out  WIDTH  to `Alu` `i_r`/`i_s`.
- `o_alu_aluc`  out  ALUC_W  to `Alu` `i_aluc`.
- `i_alu_out`  in  WIDTH  from `Alu` `o_alu`.
- `i_alu_zf`  in  1  from `Alu` `o_zf`.

## Operation
- **Slot free:** slot N is free = `!o_rspN_valid || i_rspN_ready`. A slot being drained this cycle counts as free.
- **Eligibility:** requester N is eligible = `i_reqN_valid && slot N free`.
- **Grant:** at most one grant per cycle.
  - Only one requester eligible: that requester is granted.
  - Both eligible: the one selected by the priority pointer `prio` is granted. `prio` = 0 means requester 0 wins.
- **Priority pointer:** `prio` updates only on a grant, and points to the requester not granted. A requester with a free slot and a continuously asserted valid is granted within 2 cycles.
- **Ready:** `o_reqN_ready` = grant N. It is combinational from valid and slot state. Requesters must not make valid depend on ready.
- **ALU drive:** when requester N is granted, `o_alu_*` = `i_reqN_*`. With no grant, `o_alu_*` = 0.
- **Capture:** on the edge where requester N is granted:
  - `o_rspN_alu` <= `i_alu_out`, `o_rspN_zf` <= `i_alu_zf`.
  - `o_rspN_valid` <= 1.
- **Drain:** when `o_rspN_valid && i_rspN_ready` and there is no new grant N, `o_rspN_valid` <= 0. Data is held (don't-care).
- **Drain and grant together:** new data loads and valid stays 1. Back-to-back throughput is preserved.
- **No grant:** no response register changes except by drain.
- **Request hold:** requester inputs are sampled only at the granting edge. The requester holds them stable while valid and not ready.

## Timing
- **Reset:** asynchronous, on `i_rst_n` low.
  - `o_rspN_valid` = 0, `o_rspN_alu` = 0, `o_rspN_zf` = 0, `prio` = 0.
  - `o_reqN_ready` = 0 and `o_alu_*` = 0 while valids are low. They follow the combinational rules otherwise.
  - A reset mid-operation discards pending responses. The operation granted in the reset cycle is lost.
- **Latency:** an operation granted in cycle t shows `o_rspN_valid` = 1 with its result from cycle t+1.
- **Throughput:** one operation per cycle aggregate. Each requester gets one per cycle when it is the only one eligible.
- **Critical path:** the `Alu` combinational path (arbiter mux -> `Alu` -> response register) must close in one cycle. No extra pipelining inside the block.
- **Backpressure:** while `o_rspN_valid` = 1 and `i_rspN_ready` = 0, `o_reqN_ready` = 0. Requester N's outputs hold unchanged.

## Test plan
The bench uses a stub `Alu`: `i_alu_out` = `o_alu_r + o_alu_s`, `i_alu_zf` = (sum == 0).
- **Reset:** assert `i_rst_n` = 0 mid-run with both response slots full -> all `o_rsp*` zero immediately (before next edge). After release, with `i_req0_valid` = 1, `o_req0_ready` = 1.
- **Single op:** req0 r = 5, s = 3, `i_rsp0_ready` = 1 -> `o_req0_ready` = 1 in cycle t. In t+1, `o_rsp0_valid` = 1, `o_rsp0_alu` = 8, `o_rsp0_zf` = 0.
- **Zero flag:** req1 r = 7, s = 32'hFFFF_FFF9 -> `o_rsp1_alu` = 0, `o_rsp1_zf` = 1.
- **Conflict:** both valid for 6 cycles after reset, both rsp_ready = 1 -> grant sequence 0, 1, 0, 1, 0, 1. Each response carries its own operands' sum.
- **Backpressure:** `i_rsp0_ready` = 0 with rsp0 full and both requesting.
  - `o_req0_ready` = 0, rsp0 data holds, req1 granted every cycle.
  - Raise `i_rsp0_ready` -> req0 granted in that same cycle, with the new result in the next cycle.
- **Pass-through:** req0 issues 4 back-to-back ops (1+1, 2+2, 3+3, 4+4), `i_rsp0_ready` = 1 throughout -> `o_rsp0_valid` continuously 1 for 4 cycles with 2, 4, 6, 8.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational Alu between two requesters.
// Each requester owns a response slot that holds its captured result until consumed.

module alu_arbiter_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] res,
  input  logic             zero,
  output logic             valid,
  output logic [WIDTH-1:0] alu,
  output logic             zf
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      alu   <= '0;
      zf    <= 1'b0;
    end else if (load) begin
      // a fresh grant wins over a same-cycle drain so back-to-back ops stream
      valid <= 1'b1;
      alu   <= res;
      zf    <= zero;
    end else if (take) begin
      valid <= 1'b0;
    end
  end
endmodule

module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int ALUC_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [WIDTH-1:0]  i_req0_r,
  input  logic [WIDTH-1:0]  i_req0_s,
  input  logic [ALUC_W-1:0] i_req0_aluc,
  output logic              o_rsp0_valid,
  input  logic              i_rsp0_ready,
  output logic [WIDTH-1:0]  o_rsp0_alu,
  output logic              o_rsp0_zf,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [WIDTH-1:0]  i_req1_r,
  input  logic [WIDTH-1:0]  i_req1_s,
  input  logic [ALUC_W-1:0] i_req1_aluc,
  output logic              o_rsp1_valid,
  input  logic              i_rsp1_ready,
  output logic [WIDTH-1:0]  o_rsp1_alu,
  output logic              o_rsp1_zf,
  output logic [WIDTH-1:0]  o_alu_r,
  output logic [WIDTH-1:0]  o_alu_s,
  output logic [ALUC_W-1:0] o_alu_aluc,
  input  logic [WIDTH-1:0]  i_alu_out,
  input  logic              i_alu_zf
);
  localparam int NUM_REQ = 2;

  logic [NUM_REQ-1:0]             req_valid, rsp_ready, rsp_valid;
  logic [NUM_REQ-1:0]             free, elig, grant;
  logic [NUM_REQ-1:0][WIDTH-1:0]  req_r, req_s, rsp_alu;
  logic [NUM_REQ-1:0][ALUC_W-1:0] req_aluc;
  logic [NUM_REQ-1:0]             rsp_zf;
  logic                           prio;

  assign req_valid = {i_req1_valid, i_req0_valid};
  assign rsp_ready = {i_rsp1_ready, i_rsp0_ready};
  assign req_r     = {i_req1_r, i_req0_r};
  assign req_s     = {i_req1_s, i_req0_s};
  assign req_aluc  = {i_req1_aluc, i_req0_aluc};

  // a slot draining this cycle can accept a new result on the same edge
  assign free = ~rsp_valid | rsp_ready;
  assign elig = req_valid & free;

  always_comb begin
    grant = elig;
    if (&elig) grant = prio ? 2'b10 : 2'b01;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)    prio <= 1'b0;
    else if (|grant) prio <= grant[0];
  end

  always_comb begin
    o_alu_r    = '0;
    o_alu_s    = '0;
    o_alu_aluc = '0;
    for (int n = 0; n < NUM_REQ; n++) begin
      if (grant[n]) begin
        o_alu_r    = req_r[n];
        o_alu_s    = req_s[n];
        o_alu_aluc = req_aluc[n];
      end
    end
  end

  for (genvar n = 0; n < NUM_REQ; n++) begin : g_slot
    alu_arbiter_slot #(.WIDTH(WIDTH)) u_slot (
      .clk  (i_clk),
      .rst_n(i_rst_n),
      .load (grant[n]),
      .take (rsp_ready[n]),
      .res  (i_alu_out),
      .zero (i_alu_zf),
      .valid(rsp_valid[n]),
      .alu  (rsp_alu[n]),
      .zf   (rsp_zf[n])
    );
  end

  assign o_req0_ready = grant[0];
  assign o_req1_ready = grant[1];
  assign o_rsp0_valid = rsp_valid[0];
  assign o_rsp1_valid = rsp_valid[1];
  assign o_rsp0_alu   = rsp_alu[0];
  assign o_rsp1_alu   = rsp_alu[1];
  assign o_rsp0_zf    = rsp_zf[0];
  assign o_rsp1_zf    = rsp_zf[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: stub adder Alu, directed scenarios plus random traffic
// checked against a transaction-level model of slots and round-robin priority.

module tb_alu_arbiter;
  localparam int WIDTH  = 32;
  localparam int ALUC_W = 4;

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_req0_valid = 0, i_req1_valid = 0;
  logic              o_req0_ready, o_req1_ready;
  logic [WIDTH-1:0]  i_req0_r = 0, i_req0_s = 0, i_req1_r = 0, i_req1_s = 0;
  logic [ALUC_W-1:0] i_req0_aluc = 0, i_req1_aluc = 0;
  logic              o_rsp0_valid, o_rsp1_valid;
  logic              i_rsp0_ready = 0, i_rsp1_ready = 0;
  logic [WIDTH-1:0]  o_rsp0_alu, o_rsp1_alu;
  logic              o_rsp0_zf, o_rsp1_zf;
  logic [WIDTH-1:0]  o_alu_r, o_alu_s, i_alu_out;
  logic [ALUC_W-1:0] o_alu_aluc;
  logic              i_alu_zf;

  assign i_alu_out = o_alu_r + o_alu_s;
  assign i_alu_zf  = (i_alu_out == '0);

  always #5 i_clk = ~i_clk;

  alu_arbiter #(.WIDTH(WIDTH), .ALUC_W(ALUC_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
    .i_req0_r(i_req0_r), .i_req0_s(i_req0_s), .i_req0_aluc(i_req0_aluc),
    .o_rsp0_valid(o_rsp0_valid), .i_rsp0_ready(i_rsp0_ready),
    .o_rsp0_alu(o_rsp0_alu), .o_rsp0_zf(o_rsp0_zf),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
    .i_req1_r(i_req1_r), .i_req1_s(i_req1_s), .i_req1_aluc(i_req1_aluc),
    .o_rsp1_valid(o_rsp1_valid), .i_rsp1_ready(i_rsp1_ready),
    .o_rsp1_alu(o_rsp1_alu), .o_rsp1_zf(o_rsp1_zf),
    .o_alu_r(o_alu_r), .o_alu_s(o_alu_s), .o_alu_aluc(o_alu_aluc),
    .i_alu_out(i_alu_out), .i_alu_zf(i_alu_zf)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stimulus per requester
  bit               v[2], rr[2];
  logic [WIDTH-1:0] r[2], s[2];
  logic [ALUC_W-1:0] a[2];

  // model: which slots hold a result, what it is, whose turn it is on a tie
  bit               m_full[2];
  logic [WIDTH-1:0] m_res[2];
  bit               m_zf[2];
  int               m_turn;
  int               m_winner;   // -1 when no one granted
  logic [1:0]       dut_grant;

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_full[n] = 0; m_res[n] = '0; m_zf[n] = 0;
    end
    m_turn = 0;
  endtask

  task automatic check_rsp(input string tag);
    chk({tag, "_v0"}, 64'(o_rsp0_valid), 64'(m_full[0]));
    chk({tag, "_v1"}, 64'(o_rsp1_valid), 64'(m_full[1]));
    if (m_full[0]) begin
      chk({tag, "_d0"}, 64'(o_rsp0_alu), 64'(m_res[0]));
      chk({tag, "_z0"}, 64'(o_rsp0_zf), 64'(m_zf[0]));
    end
    if (m_full[1]) begin
      chk({tag, "_d1"}, 64'(o_rsp1_alu), 64'(m_res[1]));
      chk({tag, "_z1"}, 64'(o_rsp1_zf), 64'(m_zf[1]));
    end
  endtask

  // one clock: drive stimulus after negedge, check comb outputs, advance, check registers
  task automatic step(input string tag);
    bit want[2];
    logic [WIDTH-1:0] sum;
    i_req0_valid = v[0]; i_req0_r = r[0]; i_req0_s = s[0]; i_req0_aluc = a[0];
    i_req1_valid = v[1]; i_req1_r = r[1]; i_req1_s = s[1]; i_req1_aluc = a[1];
    i_rsp0_ready = rr[0]; i_rsp1_ready = rr[1];
    #1;
    for (int n = 0; n < 2; n++) want[n] = v[n] && (!m_full[n] || rr[n]);
    if (want[0] && want[1]) m_winner = m_turn;
    else if (want[0])       m_winner = 0;
    else if (want[1])       m_winner = 1;
    else                    m_winner = -1;
    dut_grant = {o_req1_ready, o_req0_ready};
    chk({tag, "_rdy0"}, 64'(o_req0_ready), 64'(m_winner == 0));
    chk({tag, "_rdy1"}, 64'(o_req1_ready), 64'(m_winner == 1));
    if (m_winner < 0) begin
      chk({tag, "_alur"}, 64'(o_alu_r), 64'd0);
      chk({tag, "_alus"}, 64'(o_alu_s), 64'd0);
      chk({tag, "_aluc"}, 64'(o_alu_aluc), 64'd0);
    end else begin
      chk({tag, "_alur"}, 64'(o_alu_r), 64'(r[m_winner]));
      chk({tag, "_alus"}, 64'(o_alu_s), 64'(s[m_winner]));
      chk({tag, "_aluc"}, 64'(o_alu_aluc), 64'(a[m_winner]));
    end
    @(posedge i_clk);
    for (int n = 0; n < 2; n++) begin
      if (m_winner == n) begin
        sum = r[n] + s[n];
        m_full[n] = 1; m_res[n] = sum; m_zf[n] = (sum == 0);
      end else if (rr[n]) begin
        m_full[n] = 0;
      end
    end
    if (m_winner >= 0) m_turn = 1 - m_winner;
    @(negedge i_clk);
    check_rsp(tag);
  endtask

  task automatic idle_inputs();
    for (int n = 0; n < 2; n++) begin
      v[n] = 0; rr[n] = 0; r[n] = '0; s[n] = '0; a[n] = '0;
    end
  endtask

  initial begin
    idle_inputs();
    model_reset();
    @(negedge i_clk);
    #1;
    check_rsp("rst0");
    chk("rst0_rdy0", 64'(o_req0_ready), 64'd0);
    chk("rst0_alur", 64'(o_alu_r), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // single op with result next cycle
    idle_inputs();
    v[0] = 1; r[0] = 5; s[0] = 3; rr[0] = 1;
    step("single");
    chk("single_g", 64'(dut_grant), 64'd1);
    chk("single_alu", 64'(o_rsp0_alu), 64'd8);
    chk("single_zf", 64'(o_rsp0_zf), 64'd0);

    // zero flag from wraparound
    idle_inputs();
    rr[0] = 1;
    v[1] = 1; r[1] = 7; s[1] = 32'hFFFF_FFF9; rr[1] = 1;
    step("zero");
    chk("zero_alu", 64'(o_rsp1_alu), 64'd0);
    chk("zero_zf", 64'(o_rsp1_zf), 64'd1);
    idle_inputs(); rr[0] = 1; rr[1] = 1;
    step("drain");

    // reset to clear priority, then six cycles of contention alternate
    i_rst_n = 1'b0; #1; model_reset();
    @(negedge i_clk); i_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      v[0] = 1; v[1] = 1; rr[0] = 1; rr[1] = 1;
      r[0] = 32'(100 + i); s[0] = 32'(i); r[1] = 32'(200 + i); s[1] = 32'(3 * i);
      a[0] = 4'(i); a[1] = 4'(i + 8);
      step("conflict");
      chk("conflict_g", 64'(dut_grant), 64'(1 << (i % 2)));
    end

    // fill slot 0, then hold it under backpressure while req1 streams
    idle_inputs(); rr[1] = 1;
    v[0] = 1; r[0] = 40; s[0] = 2;
    step("bp_fill");
    for (int i = 0; i < 4; i++) begin
      v[0] = 1; r[0] = 9; s[0] = 9; rr[0] = 0;
      v[1] = 1; r[1] = 32'(i); s[1] = 32'(i); rr[1] = 1;
      step("bp_hold");
      chk("bp_g", 64'(dut_grant), 64'd2);
      chk("bp_keep", 64'(o_rsp0_alu), 64'd42);
    end
    rr[0] = 1;
    step("bp_release");
    chk("bp_rel_g", 64'(dut_grant), 64'd1);
    chk("bp_rel_alu", 64'(o_rsp0_alu), 64'd18);

    // back-to-back stream keeps the slot continuously valid
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      v[0] = 1; r[0] = 32'(i); s[0] = 32'(i); rr[0] = 1;
      step("stream");
      chk("stream_v", 64'(o_rsp0_valid), 64'd1);
      chk("stream_alu", 64'(o_rsp0_alu), 64'(2 * i));
    end

    // both slots full, then reset clears outputs before the next edge
    idle_inputs();
    v[0] = 1; r[0] = 11; s[0] = 1;
    step("full0");
    v[0] = 0; v[1] = 1; r[1] = 12; s[1] = 1;
    step("full1");
    i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_v0", 64'(o_rsp0_valid), 64'd0);
    chk("arst_v1", 64'(o_rsp1_valid), 64'd0);
    chk("arst_d0", 64'(o_rsp0_alu), 64'd0);
    chk("arst_d1", 64'(o_rsp1_alu), 64'd0);
    chk("arst_z1", 64'(o_rsp1_zf), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    idle_inputs();
    v[0] = 1; r[0] = 1; s[0] = 2;
    step("post_rst");
    chk("post_rst_g", 64'(dut_grant), 64'd1);

    // random traffic: requests held until accepted, consumers randomly stall
    idle_inputs();
    for (int i = 0; i < 1500; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!v[n] && ($urandom_range(0, 3) != 0)) begin
          v[n] = 1;
          r[n] = ($urandom_range(0, 7) == 0) ? 32'(0) : $urandom;
          s[n] = ($urandom_range(0, 7) == 0) ? (32'(0) - r[n]) : $urandom;
          a[n] = 4'($urandom_range(0, 15));
        end
        rr[n] = ($urandom_range(0, 2) != 0);
      end
      step("rand");
      for (int n = 0; n < 2; n++)
        if (m_winner == n) v[n] = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
